// File: rtl/com_rd_sched_pkg.sv
// Shared widths, dump length and FSM/owner encodings for the com read-port scheduler.
package com_rd_sched_pkg;
  localparam int PARAM_W              = 16;
  localparam int LOG2_NUM_OF_PARAM    = 4;
  localparam int LOG2_PARAM_MEM_DEPTH = 3;
  localparam int ADDR_W               = LOG2_NUM_OF_PARAM + LOG2_PARAM_MEM_DEPTH;
  localparam int DUMP_LEN             = 1 << ADDR_W;
  localparam int CNT_W                = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} sched_st_e;
  typedef enum logic {OWN_HOST, OWN_DUMP} owner_e;
endpackage

// File: rtl/com_rd_sched_if.sv
// Host, com read port and dump stream signals of com_rd_sched; master = scheduler side.
interface com_rd_sched_if;
  import com_rd_sched_pkg::*;
  logic               hybd_done;
  logic               host_req;
  logic [ADDR_W-1:0]  host_addr;
  logic               host_rdy;
  logic [PARAM_W-1:0] host_data;
  logic               dump_start;
  logic               dump_busy;
  logic               com_req;
  logic [ADDR_W-1:0]  com_addr;
  logic               com_rdy;
  logic [PARAM_W-1:0] com_data;
  logic               m_valid;
  logic               m_ready;
  logic [PARAM_W-1:0] m_data;
  logic               m_last;

  modport master (
    input  hybd_done, host_req, host_addr, dump_start, com_rdy, com_data, m_ready,
    output host_rdy, host_data, dump_busy, com_req, com_addr, m_valid, m_data, m_last
  );
  modport slave (
    output hybd_done, host_req, host_addr, dump_start, com_rdy, com_data, m_ready,
    input  host_rdy, host_data, dump_busy, com_req, com_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/com_dump_ostage.sv
// Single-entry valid/ready output register for the dump stream.
// With COM_DUMP_CHKSUM_EN the running sum is emitted as an extra final word carrying m_last.
module com_dump_ostage
  import com_rd_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               load,
  input  logic [PARAM_W-1:0] data,
  input  logic               last_word,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [PARAM_W-1:0] m_data,
  output logic               m_last
);
  logic pop;
  assign pop = m_valid & m_ready;

`ifdef COM_DUMP_CHKSUM_EN
  logic [PARAM_W-1:0] sum_q;
  logic               sum_pend_q;
  logic               sum_load;
  // the sum word follows the last data word as soon as the register frees up
  assign sum_load = sum_pend_q & (~m_valid | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q      <= '0;
      sum_pend_q <= 1'b0;
    end else if (clr) begin
      sum_q      <= '0;
      sum_pend_q <= 1'b0;
    end else begin
      if (load) sum_q <= sum_q + data;
      if (load && last_word) sum_pend_q <= 1'b1;
      else if (sum_load)     sum_pend_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (clr) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= data;
`ifdef COM_DUMP_CHKSUM_EN
      m_last  <= 1'b0;
`else
      m_last  <= last_word;
`endif
`ifdef COM_DUMP_CHKSUM_EN
    end else if (sum_load) begin
      m_valid <= 1'b1;
      m_data  <= sum_q;
      m_last  <= 1'b1;
`endif
    end else if (pop) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/com_rd_sched.sv
// com_rd_sched: arbitrates the single com read port between host reads and the 128-word auto-dump.
// Build option COM_DUMP_CHKSUM_EN appends a 16-bit checksum word to the dump.
module com_rd_sched
  import com_rd_sched_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  com_rd_sched_if.master bus
);
  sched_st_e          state_q, state_d;
  owner_e             owner_q, rr_q, grant_own;
  logic               grant;
  logic [CNT_W-1:0]   dump_cnt_q;
  logic               dump_busy_q;
  logic               host_rdy_q;
  logic [PARAM_W-1:0] host_data_q;
  logic               m_valid, m_last;
  logic [PARAM_W-1:0] m_data;
  logic               host_elig, dump_elig, start_acc, capture, dump_cap, host_cap;

  // host_rdy cycle still sees host_req high; it must not re-grant the retired request
  assign host_elig = bus.host_req & ~host_rdy_q;
  assign dump_elig = dump_busy_q & ~dump_cnt_q[ADDR_W] & (~m_valid | bus.m_ready);
  assign start_acc = bus.dump_start & ~dump_busy_q;
  assign capture   = (state_q == ST_WAIT) & bus.com_rdy;
  assign dump_cap  = capture & (owner_q == OWN_DUMP);
  assign host_cap  = capture & (owner_q == OWN_HOST);

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_own = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.hybd_done && (host_elig || dump_elig)) begin
          grant     = 1'b1;
          grant_own = (host_elig && dump_elig) ? rr_q : (host_elig ? OWN_HOST : OWN_DUMP);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.com_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_HOST;
      rr_q    <= OWN_HOST;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_own;
        rr_q    <= (grant_own == OWN_HOST) ? OWN_DUMP : OWN_HOST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rdy_q  <= 1'b0;
      host_data_q <= '0;
      dump_busy_q <= 1'b0;
      dump_cnt_q  <= '0;
    end else begin
      host_rdy_q <= host_cap;
      if (host_cap) host_data_q <= bus.com_data;
      if (start_acc) begin
        dump_busy_q <= 1'b1;
        dump_cnt_q  <= '0;
      end else begin
        if (dump_cap) dump_cnt_q <= dump_cnt_q + 1'b1;
        if (m_valid && bus.m_ready && m_last) dump_busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.com_addr = '0;
    if (state_q == ST_ISSUE)
      bus.com_addr = (owner_q == OWN_HOST) ? bus.host_addr : dump_cnt_q[ADDR_W-1:0];
  end

  com_dump_ostage u_ostage (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (start_acc),
    .load      (dump_cap),
    .data      (bus.com_data),
    .last_word (&dump_cnt_q[ADDR_W-1:0]),
    .m_ready   (bus.m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  assign bus.com_req   = (state_q == ST_ISSUE);
  assign bus.host_rdy  = host_rdy_q;
  assign bus.host_data = host_data_q;
  assign bus.dump_busy = dump_busy_q;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = m_data;
  assign bus.m_last    = m_last;
endmodule

// File: tb/tb_com_rd_sched.sv
// Directed bench for com_rd_sched: host latency, dumps, backpressure, contention, hybd_done, reset abort.
module tb_com_rd_sched;
  import com_rd_sched_pkg::*;
`ifdef COM_DUMP_CHKSUM_EN
  localparam int EXP_LEN = DUMP_LEN + 1;
`else
  localparam int EXP_LEN = DUMP_LEN;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  com_rd_sched_if bus();
  com_rd_sched dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  logic [PARAM_W-1:0] mem [DUMP_LEN];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // com model: data one cycle after com_req
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.com_rdy  <= 1'b0;
      bus.com_data <= '0;
    end else begin
      bus.com_rdy  <= bus.com_req;
      bus.com_data <= bus.com_req ? mem[bus.com_addr] : 16'hDEAD;
    end
  end

  logic [PARAM_W-1:0] wq[$];
  logic               lq[$];
  logic [ADDR_W-1:0]  aq[$];
  int                 last_hs_cyc = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_valid && bus.m_ready) begin
        wq.push_back(bus.m_data);
        lq.push_back(bus.m_last);
        last_hs_cyc = cyc;
      end
      if (bus.com_req) aq.push_back(bus.com_addr);
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] outs();
    return {bus.com_req, bus.com_addr, bus.host_rdy, bus.host_data, bus.dump_busy,
            bus.m_valid, bus.m_data, bus.m_last};
  endfunction

  task automatic do_dump(input string tag, input int stall_at, input bit contend, input bit chk_addr);
    int n = 0, bad = 0, nlast = 0, last_idx = -1, abad = 0;
    int hb_bad = 0, hpulse = 0, hlast = 0, hdata_bad = 0, stable_bad = 0, stall_req = 0;
    bit stalled = 0;
    logic [PARAM_W-1:0] hold, sum, exp;
    sum = '0;
    for (int i = 0; i < DUMP_LEN; i++) sum = sum + mem[i];
    wq.delete(); lq.delete(); aq.delete();
    bus.m_ready = 1'b1;
    bus.dump_start = 1'b1;
    if (contend) begin
      bus.host_req = 1'b1;
      bus.host_addr = 7'h55;
    end
    step();
    bus.dump_start = 1'b0;
    chk({tag, "_busy_set"}, bus.dump_busy, 1);
    while (bus.dump_busy && n < 4000) begin
      if (stall_at >= 0 && !stalled && wq.size() == stall_at && bus.m_valid) begin
        stalled = 1;
        bus.m_ready = 1'b0;
        hold = bus.m_data;
        for (int i = 0; i < 10; i++) begin
          step();
          if (!bus.m_valid || bus.m_data !== hold) stable_bad++;
          if (bus.com_req) stall_req++;
        end
        bus.m_ready = 1'b1;
        chk({tag, "_stall_stable"}, stable_bad, 0);
        chk({tag, "_stall_no_req"}, stall_req, 0);
      end
      if (contend && bus.host_rdy) begin
        if (hpulse > 0 && (cyc - hlast) != 6) hb_bad++;
        if (bus.host_data !== mem[7'h55]) hdata_bad++;
        hlast = cyc;
        hpulse++;
        if (hpulse == 10) bus.host_req = 1'b0;
      end
      step();
      n++;
    end
    chk({tag, "_no_timeout"}, n < 4000, 1);
    chk({tag, "_busy_fall"}, cyc, last_hs_cyc + 1);
    chk({tag, "_len"}, wq.size(), EXP_LEN);
    for (int i = 0; i < wq.size(); i++) begin
      exp = (i < DUMP_LEN) ? mem[i] : sum;
      if (wq[i] !== exp) bad++;
      if (lq[i]) begin
        nlast++;
        last_idx = i;
      end
    end
    chk({tag, "_data_err"}, bad, 0);
    chk({tag, "_nlast"}, nlast, 1);
    chk({tag, "_last_idx"}, last_idx, EXP_LEN - 1);
    if (chk_addr) begin
      for (int i = 0; i < aq.size(); i++) if (aq[i] !== ADDR_W'(i)) abad++;
      chk({tag, "_naddr"}, aq.size(), DUMP_LEN);
      chk({tag, "_addr_err"}, abad, 0);
    end
    if (contend) begin
      chk({tag, "_host_pulses"}, hpulse, 10);
      chk({tag, "_host_interval_err"}, hb_bad, 0);
      chk({tag, "_host_data_err"}, hdata_bad, 0);
    end
  endtask

  initial begin
    int nreq, k;
    bus.hybd_done = 1'b0; bus.host_req = 1'b0; bus.host_addr = '0;
    bus.dump_start = 1'b0; bus.m_ready = 1'b1;
    for (int i = 0; i < DUMP_LEN; i++) mem[i] = 16'h1000 + PARAM_W'(i) * 16'h0101;
    mem[7'h13] = 16'hA5A5;

    repeat (3) step();
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    step();

    // host read, uncontended: com_req at t+1, host_rdy at t+3
    bus.host_req = 1'b1;
    bus.host_addr = 7'h13;
    step();
    chk("host_com_req", bus.com_req, 1);
    chk("host_com_addr", bus.com_addr, 7'h13);
    step();
    chk("host_rdy_early", bus.host_rdy, 0);
    step();
    chk("host_rdy", bus.host_rdy, 1);
    chk("host_data", bus.host_data, 16'hA5A5);
    bus.host_req = 1'b0;
    step();
    chk("host_rdy_pulse", bus.host_rdy, 0);
    chk("host_data_hold", bus.host_data, 16'hA5A5);
    chk("host_no_rereq", bus.com_req, 0);

    do_dump("dump", -1, 0, 1);
    do_dump("bp", 40, 0, 1);
    do_dump("cont", -1, 1, 0);

    // hybd_done blocks every grant while high
    wq.delete();
    bus.hybd_done = 1'b1;
    bus.host_req = 1'b1;
    bus.host_addr = 7'h22;
    bus.dump_start = 1'b1;
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      bus.dump_start = 1'b0;
      if (bus.com_req) nreq++;
    end
    chk("hybd_block", nreq, 0);
    bus.hybd_done = 1'b0;
    step();
    chk("hybd_release", bus.com_req, 1);
    k = 0;
    while ((bus.dump_busy || bus.host_req) && k < 3000) begin
      if (bus.host_rdy) begin
        chk("hybd_host_data", bus.host_data, mem[7'h22]);
        bus.host_req = 1'b0;
      end
      step();
      k++;
    end
    chk("hybd_done_ok", k < 3000, 1);
    chk("hybd_dump_len", wq.size(), EXP_LEN);

    // reset mid-dump aborts; a fresh dump restarts at address 0
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    wq.delete();
    k = 0;
    while (wq.size() < 60 && k < 2000) begin
      step();
      k++;
    end
    chk("rst_reach60", wq.size() >= 60, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 0);
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("rst_idle", {bus.dump_busy, bus.m_valid, bus.com_req, bus.m_last}, 0);
    do_dump("redump", -1, 0, 1);

`ifdef COM_DUMP_CHKSUM_EN
    for (int i = 0; i < DUMP_LEN; i++) mem[i] = 16'h0200;
    do_dump("chksum", -1, 0, 1);
    chk("chksum_word", wq[DUMP_LEN], 16'h0000);
    chk("chksum_w127_not_last", lq[DUMP_LEN-1], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
